mandel_seq: RTL and testbench

MANDEL_SEQ -- requirements
Module: mandel_seq

---
 rtl/mandel_pkg.sv | 17 +
 rtl/mandel_coord_gen.sv | 62 ++++++
 rtl/mandel_seq.sv | 142 ++++++++++++++
 tb/tb_mandel_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot frame sequencer: FSM states,
// fixed-point coordinate word and counter width.
package mandel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_EMIT,
    S_FIN
  } state_t;

  typedef logic [31:0] coord_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/mandel_coord_gen.sv
// Raster scan generator: x/y pixel counters and the c_re/c_im accumulators.
// The accumulators step by a fixed STEP (add only, wrapping modulo 2^32).
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int     WIDTH   = 640,
  parameter int     HEIGHT  = 480,
  parameter coord_t X_START = 32'hFE000000,
  parameter coord_t Y_START = 32'hFF000000,
  parameter coord_t STEP    = 32'h00019999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             advance,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output coord_t           c_re,
  output coord_t           c_im,
  output logic             last_col,
  output logic             last_pix
);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  coord_t           r_re;
  coord_t           r_im;

  assign last_col = (r_x == CNT_W'(WIDTH - 1));
  assign last_pix = last_col && (r_y == CNT_W'(HEIGHT - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_re <= '0;
      r_im <= '0;
    end else if (init) begin
      r_x  <= '0;
      r_y  <= '0;
      r_re <= X_START;
      r_im <= Y_START;
    end else if (advance) begin
      if (!last_col) begin
        r_x  <= r_x + 1'b1;
        r_re <= r_re + STEP;
      end else if (!last_pix) begin
        r_x  <= '0;
        r_re <= X_START;
        r_y  <= r_y + 1'b1;
        r_im <= r_im + STEP;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign c_re = r_re;
  assign c_im = r_im;

endmodule

// File: rtl/mandel_seq.sv
// Frame sequencer: walks every pixel, loads c into the external iteration
// stage, counts iterations until divergence or the cap, and emits results.
module mandel_seq
  import mandel_pkg::*;
#(
  parameter int     WIDTH    = 640,
  parameter int     HEIGHT   = 480,
  parameter int     MAX_ITER = 256,
  parameter coord_t X_START  = 32'hFE000000,
  parameter coord_t Y_START  = 32'hFF000000,
  parameter coord_t STEP     = 32'h00019999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [31:0] c_re,
  output logic [31:0] c_im,
  output logic        ld,
  input  logic        diverged,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_iter,
  output logic        done
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] ITER_CAP  = CNT_W'(MAX_ITER);

  state_t           r_state;
  logic [CNT_W-1:0] r_iter;
  logic             r_busy;
  logic             r_ld;
  logic             r_pix_valid;
  logic             r_done;
  logic [CNT_W-1:0] r_pix_x;
  logic [CNT_W-1:0] r_pix_y;
  logic [CNT_W-1:0] r_pix_iter;

  logic             w_init;
  logic             w_handshake;
  logic             w_last_col;
  logic             w_last_pix;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  coord_t           w_c_re;
  coord_t           w_c_im;

  assign w_init      = (r_state == S_IDLE) && start;
  assign w_handshake = (r_state == S_EMIT) && pix_ready;

  mandel_coord_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_START(X_START),
    .Y_START(Y_START),
    .STEP   (STEP)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .init    (w_init),
    .advance (w_handshake),
    .x       (w_x),
    .y       (w_y),
    .c_re    (w_c_re),
    .c_im    (w_c_im),
    .last_col(w_last_col),
    .last_pix(w_last_pix)
  );

  // Outputs are registered alongside the state so none depends on a live input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_ld        <= 1'b0;
      r_pix_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_iter  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_ld    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_iter  <= '0;
          r_ld    <= 1'b0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (diverged || (r_iter == ITER_LAST)) begin
            r_pix_iter  <= diverged ? r_iter : ITER_CAP;
            r_pix_x     <= w_x;
            r_pix_y     <= w_y;
            r_pix_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            r_pix_valid <= 1'b0;
            if (w_last_pix) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_ld    <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign ld        = r_ld;
  assign pix_valid = r_pix_valid;
  assign done      = r_done;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_iter  = r_pix_iter;
  assign c_re      = w_c_re;
  assign c_im      = w_c_im;

endmodule

// File: tb/tb_mandel_seq.sv
// Scoreboard bench for mandel_seq: a modelled iteration stage drives diverged,
// a monitor compares every pixel handshake against a raster-order model.
module tb_mandel_seq;

  localparam int          W    = 4;
  localparam int          H    = 2;
  localparam int          MI   = 8;
  localparam logic [31:0] XS   = 32'd0;
  localparam logic [31:0] YS   = 32'd0;
  localparam logic [31:0] ST   = 32'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        diverged  = 1'b0;
  logic        pix_ready = 1'b1;
  logic        busy, ld, pix_valid, done;
  logic [31:0] c_re, c_im;
  logic [15:0] pix_x, pix_y, pix_iter;

  mandel_seq #(
    .WIDTH(W), .HEIGHT(H), .MAX_ITER(MI),
    .X_START(XS), .Y_START(YS), .STEP(ST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .c_re(c_re), .c_im(c_im), .ld(ld), .diverged(diverged),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    int          iter;
    int          lat;
    logic [31:0] cre;
    logic [31:0] cim;
  } pix_t;

  pix_t exp_q[$];
  int   k_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  bit   junk_en = 1'b0;
  bit   tie_one = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pixel whose orbit escapes at step k reports k, otherwise
  // MAX_ITER; it occupies one load cycle plus one iteration cycle per step tried.
  task automatic plan_frame(input int kmode);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_t p;
        int   k;
        case (kmode)
          0:       k = MI;
          1:       k = 0;
          default: k = $urandom_range(0, MI + 2);
        endcase
        p.x    = x;
        p.y    = y;
        p.iter = (k < MI) ? k : MI;
        p.lat  = 1 + ((k < MI) ? k + 1 : MI);
        p.cre  = XS + ST * x;
        p.cim  = YS + ST * y;
        exp_q.push_back(p);
        k_q.push_back(k);
      end
    end
  endtask

  // Iteration-stage and downstream-sink model.
  int cyc = 0;
  int k_cur = MI;
  int emit_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      cyc      = 0;
      emit_cnt = 0;
      diverged = 1'b0;
    end else begin
      if (ld) begin
        k_cur    = (k_q.size() > 0) ? k_q.pop_front() : MI;
        cyc      = 0;
        diverged = junk_en ? ($urandom_range(0, 1) == 1) : tie_one;
      end else if (busy && !pix_valid && !done) begin
        diverged = (cyc == k_cur);
        cyc++;
      end else begin
        diverged = junk_en ? ($urandom_range(0, 1) == 1) : tie_one;
      end
      if (pix_valid) emit_cnt++;
      else emit_cnt = 0;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (emit_cnt > 5);
        default: pix_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops the model queue on every handshake.
  initial begin
    pix_t        cur;
    bit          prev_v = 0, prev_rdy = 0, prev_hs = 0, prev_last = 0, prev_ld = 0, lat_on = 0;
    bit          hs_last;
    int          lat = 0;
    logic [15:0] hx = 0, hy = 0, hi = 0;
    logic [31:0] hre = 0, him = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 0; prev_rdy = 0; prev_hs = 0; prev_last = 0; prev_ld = 0; lat_on = 0; lat = 0;
        continue;
      end
      check("done_pulse", 32'(done), 32'(prev_hs && prev_last));
      if (done) done_cnt++;
      if (prev_hs && !prev_last) check("ld_after_hs", 32'(ld), 32'd1);
      if (prev_ld) check("ld_one_cycle", 32'(ld), 32'd0);
      if (ld) begin
        lat    = 0;
        lat_on = 1;
      end else if (lat_on) begin
        lat++;
        if (pix_valid) begin
          lat_on = 0;
          check("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("latency", lat, exp_q[0].lat);
        end
      end
      if (pix_valid && prev_v && !prev_rdy) begin
        check("hold_x", 32'(pix_x), 32'(hx));
        check("hold_y", 32'(pix_y), 32'(hy));
        check("hold_iter", 32'(pix_iter), 32'(hi));
        check("hold_c_re", c_re, hre);
        check("hold_c_im", c_im, him);
      end
      hs_last = 0;
      if (pix_valid && pix_ready) begin
        check("hs_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("pix_x", 32'(pix_x), cur.x);
          check("pix_y", 32'(pix_y), cur.y);
          check("pix_iter", 32'(pix_iter), cur.iter);
          check("c_re", c_re, cur.cre);
          check("c_im", c_im, cur.cim);
          hs_last = (cur.x == W - 1) && (cur.y == H - 1);
        end
      end
      prev_hs   = pix_valid && pix_ready;
      prev_last = hs_last;
      prev_ld   = ld;
      prev_v    = pix_valid;
      prev_rdy  = pix_ready;
      hx = pix_x; hy = pix_y; hi = pix_iter; hre = c_re; him = c_im;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ld"}, 32'(ld), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_c_re"}, c_re, 32'd0);
    check({tag, "_c_im"}, c_im, 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_pix_iter"}, 32'(pix_iter), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int kmode, input int rmode, input bit junk, input bit poke);
    int d0;
    int n;
    ready_mode = rmode;
    junk_en    = junk;
    tie_one    = (kmode == 1);
    plan_frame(kmode);
    d0 = done_cnt;
    pulse_start();
    #2;
    check("busy_after_start", 32'(busy), 32'd1);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        repeat (6) @(negedge clk);
        pulse_start();
      end
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    check("one_done", done_cnt - d0, 1);
    check("idle_busy", 32'(busy), 32'd0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int n;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 0, 1'b0, 1'b0);   // never diverges: every pixel hits the cap
    run_frame(1, 0, 1'b0, 1'b0);   // diverges at once: raster order and c sweep
    run_frame(0, 1, 1'b0, 1'b1);   // 5-cycle backpressure, start ignored while busy

    // Abort mid-frame during ITER of pixel (2,0).
    ready_mode = 0; junk_en = 1'b0; tie_one = 1'b0;
    plan_frame(0);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!(busy && !ld && !pix_valid && !done && c_re == 32'd2 && c_im == 32'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_iter_2_0", 32'(n < 500), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    exp_q.delete();
    k_q.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) run_frame(2, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
